// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a single SDRAM controller.
// One transaction in flight at a time; every output is a flop.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk_100m,
  input  logic       rst,
  input  logic       p0_req,
  input  logic       p0_rw_n,
  input  logic [8:0] p0_bytes,
  output logic       p0_grant,
  output logic       p0_done,
  input  logic       p1_req,
  input  logic       p1_rw_n,
  input  logic [8:0] p1_bytes,
  output logic       p1_grant,
  output logic       p1_done,
  input  logic       sdram_init_done,
  input  logic       sdram_idle,
  input  logic       sdram_wr_ack,
  input  logic       sdram_rd_ack,
  output logic       sdram_wr_req,
  output logic       sdram_rd_req,
  output logic [8:0] sdwr_bytes,
  output logic [8:0] sdrd_bytes,
  output logic       owner,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK, S_DONE} state_t;

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        rw_q, rw_d;
  logic [8:0]  bytes_q, bytes_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        owner_d, terr_d;
  logic        win, ack, tmo, busy;
  logic        p0_grant_d, p1_grant_d, p0_done_d, p1_done_d;
  logic        wr_req_d, rd_req_d;
  logic [8:0]  sdwr_bytes_d, sdrd_bytes_d;

  always_comb begin
    win     = (p0_req && p1_req) ? ~last_q : p1_req;
    ack     = rw_q ? sdram_wr_ack : sdram_rd_ack;
    cnt_inc = cnt_q + 16'd1;
    tmo     = (cnt_inc == TimeoutCnt);

    state_d = state_q;
    last_d  = last_q;
    rw_d    = rw_q;
    bytes_d = bytes_q;
    cnt_d   = cnt_q;
    owner_d = owner;
    terr_d  = timeout_err;

    case (state_q)
      S_IDLE: begin
        if (sdram_init_done && sdram_idle && (p0_req || p1_req)) begin
          state_d = S_ISSUE;
          owner_d = win;
          rw_d    = win ? p1_rw_n : p0_rw_n;
          bytes_d = win ? p1_bytes : p0_bytes;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_inc;
        if (tmo) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
        end else if (ack) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        cnt_d = cnt_inc;
        if (tmo) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
        end else if (!ack) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) last_d = owner_d;

    // Outputs are registered from the next state so they line up with state_q.
    busy         = (state_d != S_IDLE);
    p0_grant_d   = busy && !owner_d;
    p1_grant_d   = busy && owner_d;
    p0_done_d    = (state_d == S_DONE) && !owner_d;
    p1_done_d    = (state_d == S_DONE) && owner_d;
    wr_req_d     = (state_d == S_ISSUE) && rw_d;
    rd_req_d     = (state_d == S_ISSUE) && !rw_d;
    sdwr_bytes_d = (busy && rw_d) ? bytes_d : 9'd0;
    sdrd_bytes_d = (busy && !rw_d) ? bytes_d : 9'd0;
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      rw_q         <= 1'b0;
      bytes_q      <= '0;
      cnt_q        <= '0;
      owner        <= 1'b0;
      timeout_err  <= 1'b0;
      p0_grant     <= 1'b0;
      p1_grant     <= 1'b0;
      p0_done      <= 1'b0;
      p1_done      <= 1'b0;
      sdram_wr_req <= 1'b0;
      sdram_rd_req <= 1'b0;
      sdwr_bytes   <= '0;
      sdrd_bytes   <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      rw_q         <= rw_d;
      bytes_q      <= bytes_d;
      cnt_q        <= cnt_d;
      owner        <= owner_d;
      timeout_err  <= terr_d;
      p0_grant     <= p0_grant_d;
      p1_grant     <= p1_grant_d;
      p0_done      <= p0_done_d;
      p1_done      <= p1_done_d;
      sdram_wr_req <= wr_req_d;
      sdram_rd_req <= rd_req_d;
      sdwr_bytes   <= sdwr_bytes_d;
      sdrd_bytes   <= sdrd_bytes_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: per-cycle vector table plus hand sequences
// for contention, init gating, timeout and mid-transaction reset.
module tb_sdram_arbiter;

  logic       clk_100m = 1'b0;
  logic       rst = 1'b0;
  logic       p0_req = 1'b0, p0_rw_n = 1'b0;
  logic [8:0] p0_bytes = '0;
  logic       p1_req = 1'b0, p1_rw_n = 1'b0;
  logic [8:0] p1_bytes = '0;
  logic       sdram_init_done = 1'b0, sdram_idle = 1'b0;
  logic       sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
  logic       p0_grant, p0_done, p1_grant, p1_done;
  logic       sdram_wr_req, sdram_rd_req, owner, timeout_err;
  logic [8:0] sdwr_bytes, sdrd_bytes;
  logic [25:0] outs;

  assign outs = {p0_grant, p1_grant, p0_done, p1_done, sdram_wr_req, sdram_rd_req,
                 sdwr_bytes, sdrd_bytes, owner, timeout_err};

  sdram_arbiter #(.TIMEOUT(16)) dut (
    .clk_100m        (clk_100m),
    .rst             (rst),
    .p0_req          (p0_req),
    .p0_rw_n         (p0_rw_n),
    .p0_bytes        (p0_bytes),
    .p0_grant        (p0_grant),
    .p0_done         (p0_done),
    .p1_req          (p1_req),
    .p1_rw_n         (p1_rw_n),
    .p1_bytes        (p1_bytes),
    .p1_grant        (p1_grant),
    .p1_done         (p1_done),
    .sdram_init_done (sdram_init_done),
    .sdram_idle      (sdram_idle),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .sdwr_bytes      (sdwr_bytes),
    .sdrd_bytes      (sdrd_bytes),
    .owner           (owner),
    .timeout_err     (timeout_err)
  );

  always #5 clk_100m = ~clk_100m;

  typedef struct {
    logic       r0, w0;
    logic [8:0] b0;
    logic       r1, w1;
    logic [8:0] b1;
    logic       init, idle, wack, rack;
    logic       g0, g1, d0, d1, wrq, rrq;
    logic [8:0] wb, rb;
    logic       own;
  } vec_t;

  vec_t vq[$];
  int   done_q[$];
  int   n_vec = 0, n_fail = 0;
  int   both_cnt, rise_cnt, g0_cyc, g1_cyc;
  logic g0_prev, g1_prev;

  function automatic vec_t mk(input int r0, w0, b0, r1, w1, b1, init, idle, wack, rack,
                              input int g0, g1, d0, d1, wrq, rrq, wb, rb, own);
    vec_t v;
    v.r0 = r0[0]; v.w0 = w0[0]; v.b0 = b0[8:0];
    v.r1 = r1[0]; v.w1 = w1[0]; v.b1 = b1[8:0];
    v.init = init[0]; v.idle = idle[0]; v.wack = wack[0]; v.rack = rack[0];
    v.g0 = g0[0]; v.g1 = g1[0]; v.d0 = d0[0]; v.d1 = d1[0];
    v.wrq = wrq[0]; v.rrq = rrq[0]; v.wb = wb[8:0]; v.rb = rb[8:0]; v.own = own[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int dq(input int i);
    return (i < done_q.size()) ? done_q[i] : -1;
  endfunction

  task automatic clr();
    done_q.delete();
    both_cnt = 0; rise_cnt = 0; g0_cyc = 0; g1_cyc = 0;
    g0_prev = p0_grant; g1_prev = p1_grant;
  endtask

  // Controller model: ack mirrors the sampled request, so each grant takes ISSUE, ACK, DONE.
  task automatic run(input int n, input bit hold);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_100m);
      #1;
      if (p0_grant && p1_grant) both_cnt++;
      if (p0_grant && !g0_prev) rise_cnt++;
      if (p1_grant && !g1_prev) rise_cnt++;
      g0_prev = p0_grant;
      g1_prev = p1_grant;
      if (p0_grant) g0_cyc++;
      if (p1_grant) g1_cyc++;
      if (p0_done) begin
        done_q.push_back(0);
        if (!hold) p0_req = 1'b0;
      end
      if (p1_done) begin
        done_q.push_back(1);
        if (!hold) p1_req = 1'b0;
      end
      sdram_wr_ack = sdram_wr_req;
      sdram_rd_ack = sdram_rd_req;
    end
  endtask

  initial begin
    // r0 w0 b0 | r1 w1 b1 | init idle wack rack || g0 g1 d0 d1 wrq rrq wb rb own
    vq.push_back(mk(0, 0, 0,   0, 0, 0,   1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0,  0));
    vq.push_back(mk(1, 1, 256, 0, 0, 0,   1, 1, 0, 0,  1, 0, 0, 0, 1, 0, 256, 0,  0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(1, 1, 256, 0, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 1, 0, 256, 0,  0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(1, 1, 256, 0, 0, 0, 1, 1, 1, 0,  1, 0, 0, 0, 0, 0, 256, 0,  0));
    vq.push_back(mk(1, 1, 256, 0, 0, 0,   1, 1, 0, 0,  1, 0, 1, 0, 0, 0, 256, 0,  0));
    vq.push_back(mk(1, 1, 256, 1, 0, 12,  1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0,  0));
    vq.push_back(mk(1, 1, 256, 1, 0, 12,  1, 1, 0, 0,  0, 1, 0, 0, 0, 1, 0,   12, 1));
    vq.push_back(mk(0, 0, 0,   1, 1, 500, 1, 1, 1, 0,  0, 1, 0, 0, 0, 1, 0,   12, 1));
    vq.push_back(mk(0, 0, 0,   0, 1, 500, 1, 1, 1, 0,  0, 1, 0, 0, 0, 1, 0,   12, 1));
    vq.push_back(mk(0, 0, 0,   0, 0, 0,   1, 1, 0, 1,  0, 1, 0, 0, 0, 0, 0,   12, 1));
    vq.push_back(mk(0, 0, 0,   0, 0, 0,   1, 1, 1, 0,  0, 1, 0, 1, 0, 0, 0,   12, 1));
    vq.push_back(mk(1, 0, 7,   0, 0, 0,   1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0,  1));
    vq.push_back(mk(1, 0, 7,   0, 0, 0,   1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0,  1));
    vq.push_back(mk(1, 0, 7,   0, 0, 0,   1, 1, 0, 0,  1, 0, 0, 0, 0, 1, 0,   7,  0));
    vq.push_back(mk(1, 0, 7,   0, 0, 0,   1, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0,   7,  0));
    vq.push_back(mk(1, 0, 7,   0, 0, 0,   1, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0,   7,  0));
    vq.push_back(mk(0, 0, 0,   0, 0, 0,   1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0,  0));

    #3 rst = 1'b1;
    #1 chk("reset_state", 32'(outs), 32'd0);
    repeat (2) @(posedge clk_100m);
    #1 rst = 1'b0;

    foreach (vq[i]) begin
      p0_req = vq[i].r0; p0_rw_n = vq[i].w0; p0_bytes = vq[i].b0;
      p1_req = vq[i].r1; p1_rw_n = vq[i].w1; p1_bytes = vq[i].b1;
      sdram_init_done = vq[i].init; sdram_idle = vq[i].idle;
      sdram_wr_ack = vq[i].wack; sdram_rd_ack = vq[i].rack;
      @(posedge clk_100m);
      #1;
      chk($sformatf("vec%0d", i), 32'(outs),
          32'({vq[i].g0, vq[i].g1, vq[i].d0, vq[i].d1, vq[i].wrq, vq[i].rrq,
               vq[i].wb, vq[i].rb, vq[i].own, 1'b0}));
    end

    // Contention: both reads held high; p0 was served last, so p1 goes first.
    p0_req = 1'b1; p0_rw_n = 1'b0; p0_bytes = 9'd4;
    p1_req = 1'b1; p1_rw_n = 1'b0; p1_bytes = 9'd8;
    clr();
    run(40, 1'b1);
    p0_req = 1'b0; p1_req = 1'b0;
    run(8, 1'b1);
    chk("contention_count", 32'(done_q.size() >= 8), 32'd1);
    chk("contention_one_done_per_grant", 32'(rise_cnt), 32'(done_q.size()));
    chk("contention_both_grants", 32'(both_cnt), 32'd0);
    foreach (done_q[i]) chk($sformatf("contention_order%0d", i), 32'(done_q[i]), 32'((i + 1) % 2));

    // Init gating, then init falling mid-transaction.
    sdram_init_done = 1'b0; sdram_idle = 1'b1;
    p1_req = 1'b1; p1_rw_n = 1'b0; p1_bytes = 9'd3;
    clr();
    run(100, 1'b0);
    chk("init_gate_no_grant", 32'(g1_cyc), 32'd0);
    sdram_init_done = 1'b1;
    @(posedge clk_100m);
    #1 chk("init_grant_latency", 32'({p0_grant, p1_grant}), 32'b01);
    sdram_init_done = 1'b0;
    p0_req = 1'b1; p0_rw_n = 1'b0; p0_bytes = 9'd9;
    clr();
    run(10, 1'b0);
    chk("init_drop_completes", 32'(dq(0)), 32'd1);
    chk("init_drop_no_new_grant", 32'(g0_cyc), 32'd0);
    sdram_init_done = 1'b1;
    run(6, 1'b0);
    chk("init_back_grant", 32'(dq(1)), 32'd0);

    // Timeout: write with no ack.
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    chk("terr_before", 32'(timeout_err), 32'd0);
    p0_req = 1'b1; p0_rw_n = 1'b1; p0_bytes = 9'd33;
    begin
      int wr_cyc = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(posedge clk_100m);
        #1;
        if (sdram_wr_req) wr_cyc++;
        if (p0_done) seen = 1'b1;
      end
      p0_req = 1'b0;
      chk("timeout_wr_req_cycles", 32'(wr_cyc), 32'd16);
      chk("timeout_done_pulse", 32'(seen), 32'd1);
      chk("timeout_err_set", 32'({timeout_err, sdram_wr_req}), 32'b10);
    end
    repeat (3) @(posedge clk_100m);
    #1 chk("timeout_err_sticky", 32'({timeout_err, p0_grant}), 32'b10);

    // Reset during S_ACK of a p1 write.
    p1_req = 1'b1; p1_rw_n = 1'b1; p1_bytes = 9'd100;
    @(posedge clk_100m);
    #1 chk("rst_seq_issue", 32'({p1_grant, sdram_wr_req, sdwr_bytes}), 32'({2'b11, 9'd100}));
    sdram_wr_ack = 1'b1;
    @(posedge clk_100m);
    #1 chk("rst_seq_ack", 32'({p1_grant, sdram_wr_req}), 32'b10);
    rst = 1'b1;
    #1 chk("rst_mid_write", 32'(outs), 32'd0);
    sdram_wr_ack = 1'b0;
    p0_req = 1'b1; p0_rw_n = 1'b0; p0_bytes = 9'd5;
    p1_rw_n = 1'b0;
    repeat (2) @(posedge clk_100m);
    #1 chk("rst_hold", 32'(outs), 32'd0);
    rst = 1'b0;
    @(posedge clk_100m);
    #1 chk("rst_tie_p0", 32'({p0_grant, p1_grant, sdrd_bytes}), 32'({2'b10, 9'd5}));
    clr();
    run(10, 1'b0);
    chk("rst_after_p0_done", 32'(dq(0)), 32'd0);
    chk("rst_after_p1_done", 32'(dq(1)), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
